// File: rtl/oa_fifo_pkg.sv
// Shared types and helpers for the output-activation buffer (package oa_pkg).
package oa_pkg;

    localparam int unsigned ELEM_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } oa_fifo_state_t;

    // A column count of zero encodes a full row of vlen columns.
    function automatic int unsigned ncol_decode(input int unsigned code, input int unsigned vlen);
        int unsigned n;
        if (code == 32'd0) begin
            n = vlen;
        end else begin
            n = code;
        end
        return n;
    endfunction

endpackage

// File: rtl/oa_fifo_if.sv
// Row-input and word-output handshake bundle of oa_fifo.
// slave = the buffer itself, master = array drain plus OA writer.
interface oa_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int VLEN       = 16,
    parameter int DEPTH      = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [VLEN*DATA_WIDTH-1:0] in_data;
    logic                       in_last;
    logic                       oa_fifo_req;
    logic [$clog2(VLEN)-1:0]    vec_valid_num_col;
    logic                       output_valid;
    logic                       output_ready;
    logic [31:0]                output_data;
    logic [3:0]                 output_mask;
    logic                       switch_row;
    logic [$clog2(DEPTH):0]     tile_pending;

    modport slave (
        input  in_valid, in_data, in_last, vec_valid_num_col, output_ready,
        output in_ready, oa_fifo_req, output_valid, output_data, output_mask,
        switch_row, tile_pending
    );

    modport master (
        output in_valid, in_data, in_last, vec_valid_num_col, output_ready,
        input  in_ready, oa_fifo_req, output_valid, output_data, output_mask,
        switch_row, tile_pending
    );
endinterface

// File: rtl/oa_fifo_chk.sv
// Property checks for oa_fifo: a full FIFO with no complete tile and no transfer is a deadlock.
module oa_fifo_chk #(
    parameter int DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic [$clog2(DEPTH):0] count_i,
    input logic [$clog2(DEPTH):0] tile_pending_i,
    input logic                   idle_i
);
    localparam int CNW = $clog2(DEPTH) + 1;

    // A tile taller than DEPTH rows can never complete.
    a_no_tile_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !((count_i == CNW'(DEPTH)) && (tile_pending_i == CNW'(0)) && idle_i))
        else $error("oa_fifo: row FIFO full with no complete tile buffered");

endmodule

// File: rtl/oa_row_fifo.sv
// Synchronous row FIFO holding {last, row}; head is read straight from storage.
module oa_row_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNW-1:0]   count_q;
    logic [CNW-1:0]   count_d;

    // Row storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Occupancy next-state: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNW'(1);
            2'b01:   count_d = count_q - CNW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CNW'(0);
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNW'(DEPTH));
    assign empty_o = (count_q == CNW'(0));
    assign count_o = count_q;

endmodule

// File: rtl/oa_fifo.sv
// Output-activation buffer: stores array rows, requests write-back per tile, serialises rows into 32-bit words.
// Build option OA_FIFO_ZERO_MASKED_EN: force masked-off output bytes to zero.
module oa_fifo
    import oa_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VLEN       = 16,
    parameter int DEPTH      = 8
) (
    input logic       clk,
    input logic       rst_n,
    oa_fifo_if.slave  bus
);
    localparam int RW  = VLEN * DATA_WIDTH;
    localparam int CW  = $clog2(VLEN);
    localparam int NCW = CW + 1;
    localparam int WW  = NCW - 1;
    localparam int IW  = NCW + 1;
    localparam int TPW = $clog2(DEPTH) + 1;

    if (DATA_WIDTH != 8) begin : g_bad_dw
        $error("oa_fifo: DATA_WIDTH must be 8");
    end
    if ((VLEN < 4) || ((VLEN % 4) != 0)) begin : g_bad_vlen
        $error("oa_fifo: VLEN must be a multiple of 4 and at least 4");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("oa_fifo: DEPTH must be a power of 2 and at least 2");
    end

    oa_fifo_state_t  state_q, state_d;
    logic [WW-1:0]   w_q, w_d;
    logic [NCW-1:0]  ncol_q, ncol_d;
    logic [TPW-1:0]  tp_q, tp_d;
    logic            ready_en_q;

    logic            push_s, pop_s, fire_s, full_s, empty_s;
    logic            out_valid_s, last_word_s, in_ready_s;
    logic [TPW-1:0]  fifo_cnt_s;
    logic [RW:0]     head_s;
    logic [NCW:0]    ncol_p3_s;
    logic [WW-1:0]   nw_s;
    logic [IW-1:0]   elem_idx_s;
    logic [7:0]      byte_s;
    logic [31:0]     word_s;
    logic [3:0]      mask_s;
    logic [DATA_WIDTH-1:0] elems_s [VLEN];

    oa_row_fifo #(
        .WIDTH (RW + 1),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .din_i   ({bus.in_last, bus.in_data}),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (fifo_cnt_s)
    );

    oa_fifo_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .count_i        (fifo_cnt_s),
        .tile_pending_i (tp_q),
        .idle_i         (state_q == IDLE)
    );

    assign in_ready_s  = ready_en_q && !full_s;
    assign push_s      = bus.in_valid && in_ready_s;
    assign out_valid_s = (state_q == XFER) && !empty_s;
    assign fire_s      = out_valid_s && bus.output_ready;
    assign ncol_p3_s   = {1'b0, ncol_q} + IW'(3);
    assign nw_s        = ncol_p3_s[NCW:2];
    assign last_word_s = (w_q == (nw_s - WW'(1)));

    // Completed-tile counter: +1 on a last-row push, -1 in the request cycle.
    always_comb begin
        tp_d = tp_q;
        if (push_s && bus.in_last) begin
            tp_d = tp_d + TPW'(1);
        end else begin
            tp_d = tp_d;
        end
        if (state_q == REQ) begin
            tp_d = tp_d - TPW'(1);
        end else begin
            tp_d = tp_d;
        end
    end

    // Tile FSM and word index: a pop happens on the handshake of a row's last word.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ncol_d  = ncol_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tp_q != TPW'(0)) begin
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                ncol_d  = NCW'(ncol_decode(32'(bus.vec_valid_num_col), VLEN));
                w_d     = WW'(0);
                state_d = XFER;
            end
            XFER: begin
                if (fire_s && last_word_s) begin
                    pop_s = 1'b1;
                    w_d   = WW'(0);
                    if (head_s[RW]) begin
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else if (fire_s) begin
                    w_d = w_q + WW'(1);
                end else begin
                    w_d = w_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= WW'(0);
            ncol_q     <= NCW'(0);
            tp_q       <= TPW'(0);
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            ncol_q     <= ncol_d;
            tp_q       <= tp_d;
            ready_en_q <= 1'b1;
        end
    end

    // Unpack the head row into elements.
    always_comb begin
        for (int e = 0; e < VLEN; e++) begin
            elems_s[e] = head_s[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Word serialiser: elements 4w..4w+3 with column mask.
    always_comb begin
        word_s     = 32'd0;
        mask_s     = 4'd0;
        elem_idx_s = IW'(0);
        byte_s     = 8'd0;
        for (int j = 0; j < ELEM_PER_WORD; j++) begin
            elem_idx_s = {w_q, 2'b00} + IW'(j);
            mask_s[j]  = (elem_idx_s < {1'b0, ncol_q});
            if (elem_idx_s < IW'(VLEN)) begin
                byte_s = elems_s[elem_idx_s[CW-1:0]];
            end else begin
                byte_s = 8'd0;
            end
`ifdef OA_FIFO_ZERO_MASKED_EN
            byte_s = mask_s[j] ? byte_s : 8'd0;
`else
            byte_s = byte_s;
`endif
            word_s[j*8 +: 8] = byte_s;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.oa_fifo_req  = (state_q == REQ);
    assign bus.output_valid = out_valid_s;
    assign bus.output_data  = out_valid_s ? word_s : 32'd0;
    assign bus.output_mask  = out_valid_s ? mask_s : 4'd0;
    assign bus.switch_row   = out_valid_s && last_word_s;
    assign bus.tile_pending = tp_q;

endmodule

// File: tb/tb_oa_fifo.sv
// Directed self-checking bench for oa_fifo (VLEN=16, DEPTH=8).
module tb_oa_fifo;
    import oa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic [31:0] cap_data [64];
    logic [3:0]  cap_mask [64];
    logic        cap_sw   [64];
    int          cap_cyc  [64];
    int          cap_n = 0;
    int          req_cyc  [16];
    int          req_n = 0;

    localparam logic [127:0] R0 = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] R1 = 128'h201F1E1D1C1B1A191817161514131211;

    always #5 clk = ~clk;

    oa_fifo_if #(.DATA_WIDTH(8), .VLEN(16), .DEPTH(8)) bus ();

    oa_fifo #(.DATA_WIDTH(8), .VLEN(16), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Word and request monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.output_valid && bus.output_ready && cap_n < 64) begin
            cap_data[cap_n] <= bus.output_data;
            cap_mask[cap_n] <= bus.output_mask;
            cap_sw[cap_n]   <= bus.switch_row;
            cap_cyc[cap_n]  <= cyc;
            cap_n           <= cap_n + 1;
        end
        if (rst_n && bus.oa_fifo_req && req_n < 16) begin
            req_cyc[req_n] <= cyc;
            req_n          <= req_n + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [127:0] d, input logic l);
        int b;
        b = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && b < 200) begin
            step();
            b++;
        end
        n_checks++;
        if (b >= 200) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_words(input int target, input int budget);
        int b;
        b = 0;
        while (cap_n < target && b < budget) begin
            step();
            b++;
        end
        n_checks++;
        if (cap_n < target) begin
            n_fail++;
            $display("FAIL word_timeout: got %0d words required %0d", cap_n, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.oa_fifo_req, bus.output_valid, bus.switch_row,
             bus.output_mask, bus.output_data, bus.tile_pending} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b req=%b valid=%b sw=%b mask=%h data=%h tp=%0d required all 0",
                     bus.in_ready, bus.oa_fifo_req, bus.output_valid, bus.switch_row,
                     bus.output_mask, bus.output_data, bus.tile_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.output_valid !== 1'b0 || bus.tile_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b tp=%0d required 0 0", bus.output_valid, bus.tile_pending);
        end
    endtask

    task automatic test_single_tile();
        int base, rbase;
        logic [127:0] rows [2];
        logic [127:0] r;
        logic [31:0]  exp;
        rows[0] = R0;
        rows[1] = R1;
        base  = cap_n;
        rbase = req_n;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready = 1'b1;
        push_row(R0, 1'b0);
        push_row(R1, 1'b1);
        wait_words(base + 8, 60);
        repeat (3) step();
        n_checks++;
        if (req_n - rbase !== 1) begin
            n_fail++;
            $display("FAIL single_req_count: got %0d required 1", req_n - rbase);
        end
        n_checks++;
        if (cap_n - base !== 8) begin
            n_fail++;
            $display("FAIL single_word_count: got %0d required 8", cap_n - base);
        end
        for (int k = 0; k < 8; k++) begin
            r   = rows[k/4];
            exp = r[(k%4)*32 +: 32];
            n_checks++;
            if (cap_data[base+k] !== exp || cap_mask[base+k] !== 4'hF || cap_sw[base+k] !== (k % 4 == 3)) begin
                n_fail++;
                $display("FAIL single_word%0d: data=%h mask=%h sw=%b required %h F %b",
                         k, cap_data[base+k], cap_mask[base+k], cap_sw[base+k], exp, (k % 4 == 3));
            end
        end
        n_checks++;
        if (dut.state_q !== IDLE || bus.output_valid !== 1'b0 || bus.tile_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL single_idle: state=%0d valid=%b tp=%0d required 0 0 0",
                     dut.state_q, bus.output_valid, bus.tile_pending);
        end
    endtask

    task automatic test_ncol6();
        int base;
        logic [31:0] exp1;
`ifdef OA_FIFO_ZERO_MASKED_EN
        exp1 = 32'h00000605;
`else
        exp1 = 32'h08070605;
`endif
        base = cap_n;
        bus.vec_valid_num_col = 4'd6;
        bus.output_ready = 1'b1;
        push_row(R0, 1'b1);
        wait_words(base + 2, 40);
        repeat (3) step();
        n_checks++;
        if (cap_n - base !== 2) begin
            n_fail++;
            $display("FAIL ncol6_count: got %0d words required 2", cap_n - base);
        end
        n_checks++;
        if (cap_data[base] !== 32'h04030201 || cap_mask[base] !== 4'hF || cap_sw[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL ncol6_word0: data=%h mask=%h sw=%b required 04030201 F 0",
                     cap_data[base], cap_mask[base], cap_sw[base]);
        end
        n_checks++;
        if (cap_data[base+1] !== exp1 || cap_mask[base+1] !== 4'h3 || cap_sw[base+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL ncol6_word1: data=%h mask=%h sw=%b required %h 3 1",
                     cap_data[base+1], cap_mask[base+1], cap_sw[base+1], exp1);
        end
    endtask

    task automatic test_backpressure();
        int base, b;
        logic pat [4];
        logic prev_v, prev_r, prev_s;
        logic [31:0] prev_d;
        logic [3:0]  prev_m;
        logic [31:0] exp;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        base = cap_n;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready = 1'b0;
        push_row(R1, 1'b1);
        b = 0;
        while (bus.output_valid !== 1'b1 && b < 20) begin
            step();
            b++;
        end
        n_checks++;
        if (bus.output_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid_timeout: valid=%b required 1", bus.output_valid);
        end
        prev_v = 1'b0; prev_r = 1'b0; prev_s = 1'b0; prev_d = 32'd0; prev_m = 4'd0;
        for (int c = 0; c < 8; c++) begin
            bus.output_ready = pat[c % 4];
            if (prev_v && !prev_r) begin
                n_checks++;
                if (bus.output_valid !== 1'b1 || bus.output_data !== prev_d ||
                    bus.output_mask !== prev_m || bus.switch_row !== prev_s) begin
                    n_fail++;
                    $display("FAIL bp_stable_c%0d: valid=%b data=%h mask=%h sw=%b required 1 %h %h %b",
                             c, bus.output_valid, bus.output_data, bus.output_mask, bus.switch_row,
                             prev_d, prev_m, prev_s);
                end
            end
            prev_v = bus.output_valid;
            prev_r = bus.output_ready;
            prev_d = bus.output_data;
            prev_m = bus.output_mask;
            prev_s = bus.switch_row;
            step();
        end
        bus.output_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if (cap_n - base !== 4) begin
            n_fail++;
            $display("FAIL bp_word_count: got %0d required 4", cap_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            exp = 32'h14131211 + 32'h04040404 * k;
            n_checks++;
            if (cap_data[base+k] !== exp || cap_sw[base+k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL bp_word%0d: data=%h sw=%b required %h %b", k, cap_data[base+k], cap_sw[base+k], exp, (k == 3));
            end
        end
    endtask

    task automatic test_depth_fill();
        int base;
        logic [7:0]  e;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready = 1'b0;
        base = cap_n;
        for (int r = 0; r < 8; r++) begin
            e = 8'h30 + 8'(r);
            push_row({16{e}}, (r == 7));
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL depth_full: in_ready=%b required 0", bus.in_ready);
        end
        bus.output_ready = 1'b1;
        wait_words(base + 32, 200);
        step();
        bus.output_ready = 1'b0;
        for (int k = 0; k < 32; k++) begin
            e = 8'h30 + 8'(k / 4);
            n_checks++;
            if (cap_data[base+k] !== {4{e}} || cap_mask[base+k] !== 4'hF) begin
                n_fail++;
                $display("FAIL depth_word%0d: data=%h mask=%h required %h F", k, cap_data[base+k], cap_mask[base+k], {4{e}});
            end
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL depth_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int base, rbase;
        logic [31:0] exp;
        base  = cap_n;
        rbase = req_n;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready = 1'b0;
        push_row(R0, 1'b1);
        push_row(R1, 1'b1);
        n_checks++;
        if (bus.tile_pending !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_pending: got %0d required 2", bus.tile_pending);
        end
        step();
        bus.vec_valid_num_col = 4'd4;
        bus.output_ready = 1'b1;
        wait_words(base + 5, 60);
        repeat (3) step();
        bus.output_ready = 1'b0;
        n_checks++;
        if (req_n - rbase !== 2) begin
            n_fail++;
            $display("FAIL b2b_req_count: got %0d required 2", req_n - rbase);
        end
        n_checks++;
        if (req_cyc[rbase+1] - cap_cyc[base+3] < 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles required >= 2", req_cyc[rbase+1] - cap_cyc[base+3]);
        end
        for (int k = 0; k < 4; k++) begin
            exp = 32'h04030201 + 32'h04040404 * k;
            n_checks++;
            if (cap_data[base+k] !== exp || cap_mask[base+k] !== 4'hF || cap_sw[base+k] !== (k == 3)) begin
                n_fail++;
                $display("FAIL b2b_a_word%0d: data=%h mask=%h sw=%b required %h F %b",
                         k, cap_data[base+k], cap_mask[base+k], cap_sw[base+k], exp, (k == 3));
            end
        end
        n_checks++;
        if (cap_n - base !== 5 || cap_data[base+4] !== 32'h14131211 || cap_mask[base+4] !== 4'hF || cap_sw[base+4] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_b_word: n=%0d data=%h mask=%h sw=%b required 5 14131211 F 1",
                     cap_n - base, cap_data[base+4], cap_mask[base+4], cap_sw[base+4]);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int b, base;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready = 1'b0;
        push_row(R0, 1'b1);
        b = 0;
        while (bus.output_valid !== 1'b1 && b < 20) begin
            step();
            b++;
        end
        bus.output_ready = 1'b1;
        step();
        bus.output_ready = 1'b0;
        push_row(R1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.oa_fifo_req, bus.output_valid, bus.switch_row,
             bus.output_mask, bus.output_data, bus.tile_pending} !== 43'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: in_ready=%b req=%b valid=%b sw=%b mask=%h data=%h tp=%0d required all 0",
                     bus.in_ready, bus.oa_fifo_req, bus.output_valid, bus.switch_row,
                     bus.output_mask, bus.output_data, bus.tile_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready: got %b required 1", bus.in_ready);
        end
        base = cap_n;
        bus.output_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bus.output_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_valid_c%0d: got %b required 0", c, bus.output_valid);
            end
            step();
        end
        bus.output_ready = 1'b0;
        n_checks++;
        if (cap_n !== base) begin
            n_fail++;
            $display("FAIL midrst_words: got %0d words required 0", cap_n - base);
        end
    endtask

    initial begin
        bus.in_valid          = 1'b0;
        bus.in_data           = 128'd0;
        bus.in_last           = 1'b0;
        bus.vec_valid_num_col = 4'd0;
        bus.output_ready      = 1'b0;
        test_reset();
        test_single_tile();
        test_ncol6();
        test_backpressure();
        test_depth_fill();
        test_back_to_back();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
